// File: rtl/mips_mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, funct
// codes, ALU operation codes, mux encodings, state encoding and the
// per-state control word decoder.
package mips_ctrl_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_EQ  = 4'b0101;

    // ALU B-operand source select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    // Registered control word; jump_pc is the unconditional part of pc_write
    typedef struct packed {
        logic       jump_pc;
        logic [1:0] pc_src;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       slt_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       trap;
    } ctrl_t;

    // Moore control word for a state; exec_op is the R-type ALU operation
    function automatic ctrl_t ctrl_for_state(input state_t s, input logic [3:0] exec_op);
        ctrl_t c;
        c = '0;
        case (s)
            S_IDLE: begin
                c = '0;
            end
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = exec_op;
            end
            S_ALU_WB: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = exec_op;
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.slt_sel   = (exec_op == ALU_SLT);
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALU_EQ;
                c.pc_src    = PC_ALUOUT;
            end
            S_JUMP: begin
                c.pc_src  = PC_JUMP;
                c.jump_pc = 1'b1;
            end
            S_ADDI_WB: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
                c.reg_write = 1'b1;
            end
            S_TRAP: begin
                c.trap = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath/memory bundle. The slave modport is the
// controller's view; the master modport is the datapath side.
interface mips_mc_ctrl_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             slt_sel;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_op;
    logic             trap;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;

    modport master (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_src, ir_write, mem_read, mem_write, iord,
               reg_write, reg_dst, mem_to_reg, slt_sel, alu_src_a,
               alu_src_b, alu_op, trap, retired, state
    );

    modport slave (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_src, ir_write, mem_read, mem_write, iord,
               reg_write, reg_dst, mem_to_reg, slt_sel, alu_src_a,
               alu_src_b, alu_op, trap, retired, state
    );
endinterface

// File: rtl/mips_mc_ctrl_alu_decoder.sv
// R-type funct to ALU operation decoder, with an illegal-funct flag.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       illegal
);

    // Map funct to ALU op; unknown codes flag illegal and select AND
    always_comb begin
        alu_op  = ALU_AND;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLT:  alu_op = ALU_SLT;
            default: begin
                alu_op  = ALU_AND;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit (lw, sw, beq, j, addi, R-type ALU ops).
// Optional feature macro: MIPS_MEM_HANDSHAKE_EN -- when defined, FETCH,
// MEM_READ and MEM_WRITE stall on mem_ready; otherwise mem_ready is ignored.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)(
    input  logic             clk,
    input  logic             rst,
    mips_mc_ctrl_if.slave    bus
);

    state_t           state_r;
    state_t           next_s;
    ctrl_t            ctrl_r;
    logic [CNT_W-1:0] retired_r;
    logic             ready_s;
    logic             retire_s;
    logic [3:0]       dec_op_s;
    logic             fn_illegal_s;
    logic [3:0]       exec_op_s;

`ifdef MIPS_MEM_HANDSHAKE_EN
    assign ready_s = bus.mem_ready;
`else
    logic unused_mem_ready_s;
    assign unused_mem_ready_s = bus.mem_ready;
    assign ready_s = 1'b1;
`endif

    mips_alu_decoder u_alu_dec (
        .funct   (bus.funct),
        .alu_op  (dec_op_s),
        .illegal (fn_illegal_s)
    );

    // Next-state selection; each input is looked at only in its own state
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE:   next_s = S_FETCH;
            S_FETCH: begin
                if (ready_s) next_s = S_DECODE;
                else         next_s = S_FETCH;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     next_s = S_EXECUTE;
                    OP_LW, OP_SW: next_s = S_MEM_ADDR;
                    OP_BEQ:       next_s = S_BRANCH;
                    OP_J:         next_s = S_JUMP;
                    OP_ADDI:      next_s = S_ADDI_EXEC;
                    default:      next_s = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                if (bus.opcode == OP_LW) next_s = S_MEM_READ;
                else                     next_s = S_MEM_WRITE;
            end
            S_MEM_READ: begin
                if (ready_s) next_s = S_MEM_WB;
                else         next_s = S_MEM_READ;
            end
            S_MEM_WRITE: begin
                if (ready_s) next_s = S_FETCH;
                else         next_s = S_MEM_WRITE;
            end
            S_EXECUTE: begin
                if (fn_illegal_s) next_s = S_TRAP;
                else              next_s = S_ALU_WB;
            end
            S_ADDI_EXEC: next_s = S_ADDI_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: next_s = S_FETCH;
            S_TRAP:  next_s = S_TRAP;
            default: next_s = S_IDLE;
        endcase
    end

    // Retire on completion edges into FETCH; pick the R-type ALU op to register
    always_comb begin
        retire_s = 1'b0;
        if (next_s == S_FETCH) begin
            case (state_r)
                S_MEM_WB, S_MEM_WRITE, S_ALU_WB,
                S_BRANCH, S_JUMP, S_ADDI_WB: retire_s = 1'b1;
                default:                     retire_s = 1'b0;
            endcase
        end else begin
            retire_s = 1'b0;
        end
        // ALU_WB keeps the operation chosen on entry to EXECUTE
        if (next_s == S_EXECUTE) exec_op_s = dec_op_s;
        else                     exec_op_s = ctrl_r.alu_op;
    end

    // State, registered Moore control word and retired-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            ctrl_r    <= '0;
            retired_r <= '0;
        end else begin
            state_r <= next_s;
            ctrl_r  <= ctrl_for_state(next_s, exec_op_s);
            if (retire_s) retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            else          retired_r <= retired_r;
        end
    end

    // Only the memory-completion strobes in FETCH and the branch decision
    // depend on live inputs; everything else comes straight from registers
    assign bus.ir_write   = (state_r == S_FETCH) & ready_s;
    assign bus.pc_write   = ((state_r == S_FETCH) & ready_s)
                          | ((state_r == S_BRANCH) & bus.zero)
                          | ctrl_r.jump_pc;
    assign bus.pc_src     = ctrl_r.pc_src;
    assign bus.mem_read   = ctrl_r.mem_read;
    assign bus.mem_write  = ctrl_r.mem_write;
    assign bus.iord       = ctrl_r.iord;
    assign bus.reg_write  = ctrl_r.reg_write;
    assign bus.reg_dst    = ctrl_r.reg_dst;
    assign bus.mem_to_reg = ctrl_r.mem_to_reg;
    assign bus.slt_sel    = ctrl_r.slt_sel;
    assign bus.alu_src_a  = ctrl_r.alu_src_a;
    assign bus.alu_src_b  = ctrl_r.alu_src_b;
    assign bus.alu_op     = ctrl_r.alu_op;
    assign bus.trap       = ctrl_r.trap;
    assign bus.retired    = retired_r;
    assign bus.state      = state_r;

endmodule
